// File: rtl/cipher_display_ctrl.sv
// cipher_display_ctrl: captures the Encrypt ciphertext/tag and scans it onto an 8-digit 7-seg display.
// Latency: capture on the done-rise edge; An/Seg/Dp are registered, one cycle behind counter/state.
// Backpressure: none; done/page_btn are edge-detected levels, display scans freely.
//
// Ports:
//   clk       system clock, all logic on posedge
//   rst       synchronous active-low reset
//   done      Encrypt done level (0->1 edge captures C/tag)
//   tag       Encrypt tag bit, sampled with C
//   C         128-bit ciphertext
//   page_btn  debounced page-advance button (0->1 edge steps page)
//   Seg       segments {g,f,e,d,c,b,a}, active-low
//   An        digit anodes, active-low one-hot, An[0] = rightmost digit
//   Dp        decimal point, active-low
//   valid     a ciphertext has been captured since reset
//   tag_led   captured tag
//   page      page (32-bit slice of C) currently shown
//
// Build option: DISP_TAG_DP_EN lights the rightmost decimal point when the captured tag is 1.
module cipher_display_ctrl #(
  parameter int REFRESH_BITS = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         done,
  input  logic         tag,
  input  logic [127:0] C,
  input  logic         page_btn,
  output logic [6:0]   Seg,
  output logic [7:0]   An,
  output logic         Dp,
  output logic         valid,
  output logic         tag_led,
  output logic [1:0]   page
);

  localparam int CW = REFRESH_BITS + 3;

  typedef enum logic {IDLE, SHOW} state_t;

  state_t         state, state_nx;
  logic [127:0]   c_q, c_nx;
  logic           tag_q, tag_nx;
  logic [1:0]     page_nx;
  logic [CW-1:0]  cnt;
  logic           done_d, btn_d;
  logic           done_rise, btn_rise;
  logic [2:0]     dig;
  logic [6:0]     nibble_sel;
  logic [3:0]     nibble;
  logic [7:0]     an_nx;
  logic [6:0]     seg_nx;

  assign done_rise = done & ~done_d;
  assign btn_rise  = page_btn & ~btn_d;

  // Top three counter bits pick the digit; the lower REFRESH_BITS set the dwell time.
  assign dig        = cnt[CW-1:REFRESH_BITS];
  assign nibble_sel = {page, dig, 2'b00};
  assign nibble     = c_q[nibble_sel +: 4];

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Next-state: a capture always wins over a page step and resets the page.
  always_comb begin
    state_nx = state;
    c_nx     = c_q;
    tag_nx   = tag_q;
    page_nx  = page;
    case (state)
      IDLE: begin
        if (done_rise) begin
          c_nx     = C;
          tag_nx   = tag;
          page_nx  = 2'd0;
          state_nx = SHOW;
        end
      end
      SHOW: begin
        if (done_rise) begin
          c_nx    = C;
          tag_nx  = tag;
          page_nx = 2'd0;
        end else if (btn_rise) begin
          page_nx = page + 2'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Display values computed from the current (pre-edge) state; registered below.
  always_comb begin
    an_nx  = 8'hFF;
    seg_nx = 7'h7F;
    if (state == SHOW) begin
      an_nx  = ~(8'b1 << dig);
      seg_nx = hex7(nibble);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      c_q    <= '0;
      tag_q  <= 1'b0;
      page   <= 2'd0;
      cnt    <= '0;
      done_d <= 1'b0;
      btn_d  <= 1'b0;
      An     <= 8'hFF;
      Seg    <= 7'h7F;
    end else begin
      state  <= state_nx;
      c_q    <= c_nx;
      tag_q  <= tag_nx;
      page   <= page_nx;
      cnt    <= cnt + {{(CW-1){1'b0}}, 1'b1};
      done_d <= done;
      btn_d  <= page_btn;
      An     <= an_nx;
      Seg    <= seg_nx;
    end
  end

`ifdef DISP_TAG_DP_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      Dp <= 1'b1;
    end else begin
      Dp <= ~((state == SHOW) && (dig == 3'd0) && tag_q);
    end
  end
`else
  assign Dp = 1'b1;
`endif

  assign valid   = (state == SHOW);
  assign tag_led = tag_q;

endmodule

// File: tb/tb_cipher_display_ctrl.sv
// tb_cipher_display_ctrl: randomized + directed stimulus against a behavioural display model.
// Latency: expectations are queued per clock edge and checked 1 time unit after that edge.
// Backpressure: none; the monitor pops one expectation per cycle.
module tb_cipher_display_ctrl;

  localparam int RB     = 2;
  localparam int PERIOD = 1 << (RB + 3);

  logic         clk = 1'b0;
  logic         rst, done, tag, page_btn;
  logic [127:0] C;
  logic [6:0]   Seg;
  logic [7:0]   An;
  logic         Dp, valid, tag_led;
  logic [1:0]   page;

  int n_chk  = 0;
  int n_fail = 0;

  cipher_display_ctrl #(.REFRESH_BITS(RB)) dut (
    .clk(clk), .rst(rst), .done(done), .tag(tag), .C(C), .page_btn(page_btn),
    .Seg(Seg), .An(An), .Dp(Dp), .valid(valid), .tag_led(tag_led), .page(page)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       valid;
    logic       tag_led;
    logic [1:0] page;
  } exp_t;

  exp_t exp_q[$];

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: what has been captured, which page is shown, and cycles since reset.
  bit           m_show;
  logic [127:0] m_c;
  bit           m_tag;
  int           m_page;
  int           m_cyc;
  bit           m_done_prev, m_btn_prev;

  always @(posedge clk) begin
    exp_t e;
    int   d;
    bit   drise, brise;
    if (!rst) begin
      m_show = 0; m_c = '0; m_tag = 0; m_page = 0; m_cyc = 0;
      m_done_prev = 0; m_btn_prev = 0;
      e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1;
    end else begin
      d = m_cyc / (PERIOD / 8);
      if (m_show) begin
        e.an  = 8'hFF ^ (8'd1 << d);
        e.seg = hex_tab[(m_c >> (32 * m_page + 4 * d)) & 128'hF];
`ifdef DISP_TAG_DP_EN
        e.dp  = !(d == 0 && m_tag);
`else
        e.dp  = 1'b1;
`endif
      end else begin
        e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1;
      end
      drise = done && !m_done_prev;
      brise = page_btn && !m_btn_prev;
      if (drise) begin
        m_c = C; m_tag = tag; m_page = 0; m_show = 1;
      end else if (brise && m_show) begin
        m_page = (m_page + 1) % 4;
      end
      m_cyc       = (m_cyc + 1) % PERIOD;
      m_done_prev = done;
      m_btn_prev  = page_btn;
    end
    e.valid   = m_show;
    e.tag_led = m_tag;
    e.page    = m_page[1:0];
    exp_q.push_back(e);
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: one registered output set per edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 8'd1, 8'd0);
    end else begin
      e = exp_q.pop_front();
      chk("An",      An,                  e.an);
      chk("Seg",     {1'b0, Seg},         {1'b0, e.seg});
      chk("Dp",      {7'd0, Dp},          {7'd0, e.dp});
      chk("valid",   {7'd0, valid},       {7'd0, e.valid});
      chk("tag_led", {7'd0, tag_led},     {7'd0, e.tag_led});
      chk("page",    {6'd0, page},        {6'd0, e.page});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic btn_pulse();
    page_btn = 1'b1; cyc(1);
    page_btn = 1'b0; cyc(2);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    rst = 1'b0; done = 1'b1; tag = 1'b1; page_btn = 1'b0; C = rnd128();
    // Reset held with done high: blank display, nothing captured.
    cyc(3);
    chk("reset_valid", {7'd0, valid}, 8'd0);
    chk("reset_An",    An,            8'hFF);
    done = 1'b0; rst = 1'b1;
    cyc(4);
    chk("idle_no_capture", {7'd0, valid}, 8'd0);

    // First capture, page 0 shows 0..7 across one full scan.
    C = 128'h0123456789ABCDEF_FEDCBA98_76543210; tag = 1'b1;
    done = 1'b1; cyc(1);
    chk("capture_valid", {7'd0, valid}, 8'd1);
    chk("capture_page",  {6'd0, page},  8'd0);
    cyc(PERIOD + 4);

    // Page stepping with wrap.
    btn_pulse(); cyc(PERIOD);
    chk("page_step1", {6'd0, page}, 8'd1);
    btn_pulse(); btn_pulse(); btn_pulse();
    chk("page_wrap", {6'd0, page}, 8'd0);

    // Long done hold: C change mid-hold is ignored; re-raise captures and resets page.
    done = 1'b0; cyc(1);
    C = rnd128(); done = 1'b1; cyc(50);
    C = rnd128(); cyc(50);
    btn_pulse();
    done = 1'b0; cyc(2);
    C = rnd128(); done = 1'b1; cyc(1);
    chk("recapture_page", {6'd0, page}, 8'd0);
    cyc(PERIOD);

    // Simultaneous capture and page press with page 2.
    btn_pulse(); btn_pulse();
    chk("page_two", {6'd0, page}, 8'd2);
    done = 1'b0; cyc(1);
    C = rnd128(); tag = 1'b0; done = 1'b1; page_btn = 1'b1; cyc(1);
    page_btn = 1'b0;
    chk("capture_beats_btn", {6'd0, page}, 8'd0);
    cyc(PERIOD + 2);

    // done toggling every cycle captures on each rise.
    for (int i = 0; i < 16; i++) begin
      done = ~done; C = rnd128(); tag = $urandom_range(0, 1); cyc(1);
    end

    // Mid-scan reset.
    cyc(7); rst = 1'b0; cyc(2);
    chk("midscan_reset", {7'd0, valid}, 8'd0);
    rst = 1'b1; cyc(3);

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) done = ~done;
      if ($urandom_range(0, 3) == 0) page_btn = ~page_btn;
      if ($urandom_range(0, 3) == 0) C = rnd128();
      tag = $urandom_range(0, 1);
      rst = ($urandom_range(0, 299) != 0);
      cyc(1);
    end
    rst = 1'b1; done = 1'b0; page_btn = 1'b0;
    cyc(PERIOD);

    chk("scoreboard_drained", exp_q.size() > 0 ? 8'd1 : 8'd0, 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
